// File: rtl/uart_tx_fifo_cfg_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_cfg_pkg
//   Shared definitions for the configurable UART transmitter:
//   - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - parity mode constants
//   - parity bit helper
// ----------------------------------------------------------------------------
package uart_tx_fifo_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // data_xor is the XOR reduction of the data word. Even parity sends it as
  // is; odd parity inverts it so the total number of ones becomes odd.
  function automatic logic parity_bit(input int mode, input logic data_xor);
    return (mode == PAR_EVEN) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
//   Synchronous first-word-fall-through FIFO feeding the UART transmitter.
//   Pushes while full and pops while empty are ignored. Pointers wrap modulo
//   DEPTH (DEPTH must be a power of two).
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (clears pointers and count)
//   push_i   in   write wdata_i when not full
//   pop_i    in   discard the head word when not empty
//   wdata_i  in   WIDTH   word to write
//   rdata_o  out  WIDTH   current head word (valid whenever count_o != 0)
//   count_o  out  $clog2(DEPTH)+1  number of stored words
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Power-of-two depth: pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_cfg
//   Parametrised UART transmitter with an input FIFO. Frames are
//   start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop
//   bits(1); each bit lasts CLKS_PER_BIT system clocks. Queued words go out
//   back-to-back with no idle gap while en is high.
// Parameters
//   DATA_BITS 5..9, CLKS_PER_BIT >=2, PARITY 0 none/1 odd/2 even,
//   STOP_BITS 1..2, FIFO_DEPTH power of two >=2
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   en        in   allows new frames to start (FIFO writes are not gated)
//   in_valid  in   input word valid
//   in_data   in   DATA_BITS  word to transmit
//   in_ready  out  FIFO not full; push happens iff in_valid & in_ready
//   tx        out  serial line, idle high
//   busy      out  high from start bit through last stop bit
//   done      out  one-clock pulse on the last clock of the last stop bit
//   fifo_cnt  out  $clog2(FIFO_DEPTH)+1  words queued
// ----------------------------------------------------------------------------
module uart_tx_fifo_cfg
  import uart_tx_fifo_cfg_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e            state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   pop;
  logic                   start_ok;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic [CNT_W-1:0]       fifo_count;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign in_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_cnt = fifo_count;
  assign start_ok = en && (fifo_count != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // tx is registered, so the start bit is driven on the popping edge.
        if (start_ok) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          par_d   = parity_bit(PARITY, ^fifo_rdata);
          state_d = ST_START;
          baud_d  = BAUD_LAST;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (baud_q == '0) begin
          state_d = ST_DATA;
          baud_d  = BAUD_LAST;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          if (bit_q == BIT_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            // The next bit to send is shift_q[1]; it becomes shift[0].
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      ST_PARITY: begin
        if (baud_q == '0) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          baud_d  = BAUD_LAST;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_q == '0) begin
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next frame when one is waiting.
            if (start_ok) begin
              pop     = 1'b1;
              shift_d = fifo_rdata;
              par_d   = parity_bit(PARITY, ^fifo_rdata);
              state_d = ST_START;
              baud_d  = BAUD_LAST;
              tx_d    = 1'b0;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            stop_d = stop_q + 1'b1;
            baud_d = BAUD_LAST;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // done is registered: raise it for the cycle that will be the final
    // clock of the final stop bit.
    done_d = (state_d == ST_STOP) && (stop_d == STOP_LAST) && (baud_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Frame payload registers are always loaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_cfg
//   Four transmitter instances (CLKS_PER_BIT=4, FIFO_DEPTH=4):
//     0: 8 data, no parity, 1 stop
//     1: 8 data, even parity, 1 stop
//     2: 8 data, odd parity, 1 stop
//     3: 5 data, no parity, 2 stops
//   Each instance has a reference model: a queue of pending words and a queue
//   holding the expected tx level for every remaining clock of the current
//   frame. Directed checks with literal expectations pin the model.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_cfg;

  localparam int CPB = 4;
  localparam int NI  = 4;

  logic                 clk;
  logic                 rst;
  logic [NI-1:0]        en;
  logic [NI-1:0]        in_valid;
  logic [NI-1:0][8:0]   din;
  logic [NI-1:0]        tx_w, busy_w, done_w, rdy_w;
  logic [NI-1:0][2:0]   cnt_w;

  int total = 0;
  int bad   = 0;

  logic rec_tx   [NI][256];
  logic rec_busy [NI][256];
  logic rec_done [NI][256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  generate
    for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int DB = (g == 3) ? 5 : 8;
      localparam int PM = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
      localparam int SB = (g == 3) ? 2 : 1;

      bit         line[$];
      logic [8:0] fq[$];

      uart_tx_fifo_cfg #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB),
        .PARITY       (PM),
        .STOP_BITS    (SB),
        .FIFO_DEPTH   (4)
      ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en[g]),
        .in_valid (in_valid[g]),
        .in_data  (din[g][DB-1:0]),
        .in_ready (rdy_w[g]),
        .tx       (tx_w[g]),
        .busy     (busy_w[g]),
        .done     (done_w[g]),
        .fifo_cnt (cnt_w[g])
      );

      function automatic void add_frame(input logic [8:0] w);
        bit p;
        for (int c = 0; c < CPB; c++) line.push_back(1'b0);
        for (int b = 0; b < DB; b++)
          for (int c = 0; c < CPB; c++) line.push_back(w[b]);
        p = 1'b0;
        for (int b = 0; b < DB; b++) p = p ^ w[b];
        if (PM == 1) p = ~p;
        if (PM != 0)
          for (int c = 0; c < CPB; c++) line.push_back(p);
        for (int c = 0; c < SB * CPB; c++) line.push_back(1'b1);
      endfunction

      always @(posedge clk or posedge rst) begin
        if (rst) begin
          line.delete();
          fq.delete();
        end else begin
          bit         ending;
          bit         take;
          logic [8:0] w;
          ending = (line.size() <= 1);
          take   = in_valid[g] && (fq.size() < 4);
          w      = din[g] & 9'((1 << DB) - 1);
          if (line.size() != 0) line.delete(0);
          if (ending && en[g] && fq.size() != 0) add_frame(fq.pop_front());
          if (take) fq.push_back(w);
        end
      end

      always @(negedge clk) begin
        chk($sformatf("i%0d_tx", g),    tx_w[g],   (line.size() != 0) ? int'(line[0]) : 1);
        chk($sformatf("i%0d_busy", g),  busy_w[g], (line.size() != 0) ? 1 : 0);
        chk($sformatf("i%0d_done", g),  done_w[g], (line.size() == 1) ? 1 : 0);
        chk($sformatf("i%0d_cnt", g),   cnt_w[g],  fq.size());
        chk($sformatf("i%0d_ready", g), rdy_w[g],  (fq.size() != 4) ? 1 : 0);
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input logic [8:0] w);
    in_valid[k] = 1'b1;
    din[k]      = w;
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic record(input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        rec_tx[k][i]   = tx_w[k];
        rec_busy[k][i] = busy_w[k];
        rec_done[k][i] = done_w[k];
      end
    end
  endtask

  // Word of a frame whose first clock is at record index base.
  function automatic int decode(input int k, input int base, input int nb);
    int v = 0;
    for (int b = 0; b < nb; b++)
      if (rec_tx[k][base + CPB * (1 + b)]) v = v | (1 << b);
    return v;
  endfunction

  function automatic int count_done(input int k, input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (rec_done[k][i]) c++;
    return c;
  endfunction

  function automatic int last_done(input int k, input int n);
    int p = 0;
    for (int i = 1; i <= n; i++) if (rec_done[k][i]) p = i;
    return p;
  endfunction

  function automatic int count_busy(input int k, input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (rec_busy[k][i]) c++;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         low;
    int         err;
    int         got;
    logic [7:0] words [5];

    rst      = 1'b1;
    en       = '1;
    in_valid = '0;
    din      = '0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_tx",    tx_w,   4'hF);
    chk("rst_busy",  busy_w, 0);
    chk("rst_done",  done_w, 0);
    chk("rst_ready", rdy_w,  4'hF);
    chk("rst_cnt",   cnt_w,  0);

    low = 0;
    repeat (50) begin
      tick();
      if (tx_w != 4'hF) low++;
    end
    chk("idle_tx_low_cycles", low, 0);

    // 0xA5, 8N1: start + 10100101 LSB first + stop.
    push(0, 9'h0A5);
    chk("a5_tx_before_start", tx_w[0], 1);
    chk("a5_cnt_after_push",  cnt_w[0], 1);
    record(42);
    chk("a5_tx_low_next_edge", rec_tx[0][1], 0);
    err = 0;
    got = 0;
    for (int j = 0; j < 10; j++) begin
      for (int c = 1; c < CPB; c++)
        if (rec_tx[0][4 * j + 1 + c] != rec_tx[0][4 * j + 1]) err++;
      if (rec_tx[0][4 * j + 1]) got = got | (1 << j);
    end
    chk("a5_bit_stable", err, 0);
    chk("a5_bits", got, 'h34A);
    chk("a5_done_count", count_done(0, 42), 1);
    chk("a5_done_pos",   last_done(0, 42), 40);
    chk("a5_busy_len",   count_busy(0, 1, 42), 40);

    // Parity on 0x07: even -> 1, odd -> 0; frames of 44 clocks.
    in_valid[1] = 1'b1; din[1] = 9'h007;
    in_valid[2] = 1'b1; din[2] = 9'h007;
    tick();
    in_valid[1] = 1'b0;
    in_valid[2] = 1'b0;
    record(46);
    chk("even_parity_bit", rec_tx[1][37], 1);
    chk("odd_parity_bit",  rec_tx[2][37], 0);
    chk("even_busy_len",   count_busy(1, 1, 46), 44);
    chk("odd_busy_len",    count_busy(2, 1, 46), 44);
    chk("even_done_pos",   last_done(1, 46), 44);
    chk("odd_done_pos",    last_done(2, 46), 44);

    // Fill with en low: 4 accepted, 5th dropped, then 4 chained frames.
    words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h81;
    words[3] = 8'h7E; words[4] = 8'hFF;
    en[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      din[0]      = {1'b0, words[i]};
      tick();
    end
    in_valid[0] = 1'b0;
    chk("full_cnt",   cnt_w[0], 4);
    chk("full_ready", rdy_w[0], 0);
    chk("full_tx_idle", tx_w[0], 1);
    en[0] = 1'b1;
    record(170);
    chk("chain_busy_len",   count_busy(0, 1, 160), 160);
    chk("chain_done_count", count_done(0, 170), 4);
    chk("chain_done_last",  last_done(0, 170), 160);
    chk("chain_idle_after", rec_busy[0][161], 0);
    for (int f = 0; f < 4; f++)
      chk($sformatf("chain_word%0d", f), decode(0, 1 + 40 * f, 8), words[f]);

    // 5 data bits, 2 stop bits.
    push(3, 9'h01F);
    record(34);
    low = 0;
    for (int i = 25; i <= 32; i++) if (rec_tx[3][i]) low++;
    chk("stop2_high_clks", low, 8);
    chk("stop2_start_bit", rec_tx[3][1], 0);
    chk("stop2_busy_len",  count_busy(3, 1, 34), 32);
    chk("stop2_done_pos",  last_done(3, 34), 32);

    // Drop en mid-frame: frame finishes, next word stays queued.
    push(3, 9'h00A);
    push(3, 9'h015);
    repeat (10) tick();
    en[3] = 1'b0;
    record(40);
    chk("endrop_done_count", count_done(3, 40), 1);
    chk("endrop_idle",       rec_busy[3][40], 0);
    chk("endrop_cnt",        cnt_w[3], 1);
    en[3] = 1'b1;
    record(34);
    chk("endrop_resume_word", decode(3, 1, 5), 'h15);
    chk("endrop_resume_done", last_done(3, 34), 32);

    // Asynchronous reset during DATA.
    push(0, 9'h05A);
    push(0, 9'h011);
    push(0, 9'h022);
    repeat (8) tick();
    chk("prerst_busy", busy_w[0], 1);
    rst = 1'b1;
    #1;
    chk("arst_tx",   tx_w[0], 1);
    chk("arst_busy", busy_w[0], 0);
    chk("arst_cnt",  cnt_w[0], 0);
    tick();
    rst = 1'b0;
    push(0, 9'h0C3);
    record(42);
    chk("postrst_word",     decode(0, 1, 8), 'hC3);
    chk("postrst_done_pos", last_done(0, 42), 40);

    // Random traffic against the models.
    for (int t = 0; t < 2000; t++) begin
      for (int k = 0; k < NI; k++) begin
        in_valid[k] = ($urandom_range(0, 9) < 4);
        din[k]      = 9'($urandom);
        en[k]       = ($urandom_range(0, 19) != 0);
      end
      tick();
    end
    in_valid = '0;
    en       = '1;
    repeat (400) tick();
    chk("drain_busy", busy_w, 0);
    chk("drain_cnt",  cnt_w,  0);
    chk("drain_tx",   tx_w,   4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
